// File: rtl/uart_tx_128.sv
// UART 8N1 transmitter for 128-bit results: optional header byte, then 16 payload
// bytes LSB-byte first, each byte LSB-bit first. All outputs are registered.
module uart_tx_128 #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_CYC      = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_hdr_en,
  input  logic [7:0]   i_hdr,
  input  logic [127:0] i_data,
  output logic         o_txd,
  output logic         o_busy,
  output logic         o_done
);

  localparam int CNT_MAX = (CLKS_PER_BIT > GAP_CYC) ? CLKS_PER_BIT : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_t;

  state_t             r_state, w_state_n;
  logic [CNT_W-1:0]   r_baud, w_baud_n;
  logic [2:0]         r_bit, w_bit_n;
  logic [4:0]         r_byte, w_byte_n;
  logic               r_hdr_en, w_hdr_en_n;
  logic [135:0]       r_frame, w_frame_n;
  logic               r_txd, r_ready, r_busy, r_done;
  logic               w_txd_n, w_ready_n, w_busy_n, w_done_n;
  logic               w_accept, w_byte_end, w_last_byte;
  logic [7:0]         w_cur_byte;

  assign w_accept    = i_valid && r_ready;
  assign w_last_byte = (r_byte == (r_hdr_en ? 5'd16 : 5'd15));

  // Next-state logic. The frame buffer always presents the current byte in [7:0].
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_state_n  = r_state;
    w_baud_n   = r_baud + 1'b1;
    w_bit_n    = r_bit;
    w_byte_n   = r_byte;
    w_hdr_en_n = r_hdr_en;
    w_frame_n  = r_frame;
    w_byte_end = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (w_accept) begin
          w_state_n  = S_START;
          w_bit_n    = 3'd0;
          w_byte_n   = 5'd0;
          w_hdr_en_n = i_hdr_en;
          w_frame_n  = i_hdr_en ? {i_data, i_hdr} : {8'h00, i_data};
        end
      end
      S_START: begin
        if (r_baud == BIT_LAST) begin
          w_baud_n  = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (r_baud == BIT_LAST) begin
          w_baud_n = '0;
          if (r_bit == 3'd7) begin
            w_state_n = S_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_baud == BIT_LAST) begin
          w_baud_n = '0;
          if (GAP_CYC > 0) begin
            w_state_n = S_GAP;
          end else begin
            w_byte_end = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_baud == GAP_LAST) begin
          w_baud_n   = '0;
          w_byte_end = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_baud_n  = '0;
      end
    endcase

    // Byte boundary: either finish the frame or move on to the next byte.
    if (w_byte_end) begin
      if (w_last_byte) begin
        w_state_n = S_IDLE;
      end else begin
        w_state_n = S_START;
        w_bit_n   = 3'd0;
        w_byte_n  = r_byte + 5'd1;
        w_frame_n = {8'h00, r_frame[135:8]};
      end
    end
  end

  // Outputs are derived from the next state so they can be registered without latency.
  assign w_cur_byte = w_frame_n[7:0];

  always_comb begin
    w_ready_n = (w_state_n == S_IDLE);
    w_busy_n  = !w_ready_n;
    w_done_n  = (r_state != S_IDLE) && (w_state_n == S_IDLE);
    case (w_state_n)
      S_START: w_txd_n = 1'b0;
      S_DATA:  w_txd_n = w_cur_byte[w_bit_n];
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 3'd0;
      r_byte   <= 5'd0;
      r_hdr_en <= 1'b0;
      r_txd    <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_baud   <= w_baud_n;
      r_bit    <= w_bit_n;
      r_byte   <= w_byte_n;
      r_hdr_en <= w_hdr_en_n;
      r_txd    <= w_txd_n;
      r_ready  <= w_ready_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
    end
  end

  // NOTE: the payload buffer is not reset; it is always reloaded before it is read.
  always_ff @(posedge clk) begin
    r_frame <= w_frame_n;
  end

  assign o_txd   = r_txd;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_uart_tx_128.sv
// Scoreboard bench for uart_tx_128: two instances (no gap / with gap), a byte-level
// reference model per frame, and a cycle-exact serial-line monitor per instance.
module tb_uart_tx_128;

  localparam int CPB0 = 16;
  localparam int GAP0 = 0;
  localparam int CPB1 = 8;
  localparam int GAP1 = 100;
  localparam int L0   = 10 * CPB0 + GAP0;
  localparam int L1   = 10 * CPB1 + GAP1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst0, valid0, hdr_en0, ready0, txd0, busy0, done0;
  logic [7:0]   hdr0;
  logic [127:0] data0;
  logic         rst1, valid1, hdr_en1, ready1, txd1, busy1, done1;
  logic [7:0]   hdr1;
  logic [127:0] data1;

  uart_tx_128 #(.CLKS_PER_BIT(CPB0), .GAP_CYC(GAP0)) dut0 (
    .clk(clk), .rst(rst0), .i_valid(valid0), .o_ready(ready0), .i_hdr_en(hdr_en0),
    .i_hdr(hdr0), .i_data(data0), .o_txd(txd0), .o_busy(busy0), .o_done(done0)
  );

  uart_tx_128 #(.CLKS_PER_BIT(CPB1), .GAP_CYC(GAP1)) dut1 (
    .clk(clk), .rst(rst1), .i_valid(valid1), .o_ready(ready1), .i_hdr_en(hdr_en1),
    .i_hdr(hdr1), .i_data(data1), .o_txd(txd1), .o_busy(busy1), .o_done(done1)
  );

  typedef struct {
    logic [7:0] b [17];
    int         n;
    int         t_acc;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];
  bit     mon_act [2];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_txd(input int d);   return (d == 0) ? txd0   : txd1;   endfunction
  function automatic logic get_ready(input int d); return (d == 0) ? ready0 : ready1; endfunction
  function automatic logic get_busy(input int d);  return (d == 0) ? busy0  : busy1;  endfunction
  function automatic logic get_done(input int d);  return (d == 0) ? done0  : done1;  endfunction
  function automatic int   get_cpb(input int d);   return (d == 0) ? CPB0   : CPB1;   endfunction
  function automatic int   get_gap(input int d);   return (d == 0) ? GAP0   : GAP1;   endfunction

  // Reference model: the byte list the line must carry for one accepted word.
  task automatic build_frame(input logic he, input logic [7:0] h, input logic [127:0] data,
                             input int t_acc, output frame_t f);
    int k;
    k = 0;
    for (int i = 0; i < 17; i++) f.b[i] = 8'h00;
    if (he) begin
      f.b[0] = h;
      k = 1;
    end
    for (int i = 0; i < 16; i++) f.b[k + i] = data[8 * i +: 8];
    f.n     = 16 + k;
    f.t_acc = t_acc;
  endtask

  task automatic set_in(input int d, input logic v, input logic he, input logic [7:0] h,
                        input logic [127:0] data);
    if (d == 0) begin
      valid0 = v; hdr_en0 = he; hdr0 = h; data0 = data;
    end else begin
      valid1 = v; hdr_en1 = he; hdr1 = h; data1 = data;
    end
  endtask

  // Present a word, wait for the handshake edge, optionally hand the frame to the scoreboard.
  task automatic send(input int d, input logic he, input logic [7:0] h, input logic [127:0] data,
                      input bit keep_valid, input bit push, output int t_acc);
    frame_t f;
    bit     seen;
    seen = 0;
    set_in(d, 1'b1, he, h, data);
    for (int i = 0; i < 40 * L1; i++) begin
      @(negedge clk);
      if (get_ready(d) === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    if (!keep_valid) set_in(d, 1'b0, he, h, data);
    if (push) begin
      build_frame(he, h, data, t_acc, f);
      if (d == 0) q0.push_back(f);
      else        q1.push_back(f);
    end
  endtask

  // Serial-line monitor: checks every cycle of every bit slot against the expected frame.
  task automatic run_frame(input int d, input frame_t f);
    int         cpb, gap, len, t0, w;
    logic [7:0] rx;
    logic       exp_bit;
    bit         shape_ok, flags_ok;
    mon_act[d] = 1;
    cpb = get_cpb(d);
    gap = get_gap(d);
    len = 10 * cpb + gap;
    t0  = cyc;
    for (int k = 0; k < f.n; k++) begin
      w = 0;
      while (get_txd(d) !== 1'b0 && w < 4 * len) begin
        @(negedge clk);
        w++;
      end
      if (w >= 4 * len) begin
        check("start_bit_timeout", 0, 1);
        mon_act[d] = 0;
        return;
      end
      if (k == 0) begin
        t0 = cyc;
        check("first_start_cycle", cyc, f.t_acc);
      end else begin
        check("byte_start_cycle", cyc, t0 + k * len);
      end
      rx = 8'h00;
      shape_ok = 1;
      flags_ok = 1;
      for (int s = 0; s < 10; s++) begin
        exp_bit = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : f.b[k][s - 1];
        for (int c = 0; c < cpb; c++) begin
          if (get_txd(d) !== exp_bit) shape_ok = 0;
          if (c == cpb / 2 && s >= 1 && s <= 8) rx[s - 1] = get_txd(d);
          if (get_ready(d) !== 1'b0 || get_busy(d) !== 1'b1 || get_done(d) !== 1'b0) flags_ok = 0;
          @(negedge clk);
        end
      end
      for (int c = 0; c < gap; c++) begin
        if (get_txd(d) !== 1'b1) shape_ok = 0;
        if (get_ready(d) !== 1'b0 || get_busy(d) !== 1'b1 || get_done(d) !== 1'b0) flags_ok = 0;
        @(negedge clk);
      end
      check($sformatf("rx_byte[%0d]", k), rx, f.b[k]);
      check("bit_and_gap_timing", shape_ok, 1);
      check("busy_flags_in_frame", flags_ok, 1);
    end
    check("done_cycle", cyc, t0 + f.n * len);
    check("done_ready_busy", {get_done(d), get_ready(d), get_busy(d), get_txd(d)}, 4'b1101);
    @(negedge clk);
    check("done_one_cycle", get_done(d), 1'b0);
    mon_act[d] = 0;
  endtask

  task automatic monitor(input int d);
    frame_t f;
    @(negedge clk);
    forever begin
      if (d == 0 && q0.size() > 0) begin
        f = q0.pop_front();
        run_frame(d, f);
      end else if (d == 1 && q1.size() > 0) begin
        f = q1.pop_front();
        run_frame(d, f);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_idle(input int d);
    bit idle;
    idle = 0;
    for (int i = 0; i < 60 * L1; i++) begin
      @(negedge clk);
      if (((d == 0) ? q0.size() : q1.size()) == 0 && !mon_act[d]) begin
        idle = 1;
        break;
      end
    end
    if (!idle) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int           t_acc, t_dummy;
    bit           ok;
    logic [127:0] rdata;
    logic [7:0]   rhdr;
    logic         rhe;

    rst0 = 1'b1;
    rst1 = 1'b1;
    set_in(0, 1'b0, 1'b0, 8'h00, '0);
    set_in(1, 1'b0, 1'b0, 8'h00, '0);

    // Reset held for 5 cycles: idle outputs throughout.
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs_dut0", {txd0, ready0, busy0, done0}, 4'b1100);
      check("reset_outputs_dut1", {txd1, ready1, busy1, done1}, 4'b1100);
    end
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Known vector without header.
    send(0, 1'b0, 8'h00, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1, t_acc);
    wait_idle(0);

    // Header 0x40 with all-zero payload.
    send(0, 1'b1, 8'h40, 128'h0, 1'b0, 1'b1, t_acc);
    wait_idle(0);

    // A competing request while busy must be ignored.
    rdata = {$urandom, $urandom, $urandom, $urandom};
    send(0, 1'b1, 8'hA5, rdata, 1'b0, 1'b1, t_acc);
    repeat (3 * CPB0) @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b0, 8'h5A, ~rdata);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready0 !== 1'b0) ok = 0;
    end
    check("ready_low_while_busy", ok, 1);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0, 8'h00, '0);
    wait_idle(0);

    // Reset during bit 3 of byte 5: frame dropped, no completion pulse.
    rdata = {$urandom, $urandom, $urandom, $urandom};
    send(0, 1'b0, 8'h00, rdata, 1'b0, 1'b0, t_acc);
    while (cyc < t_acc + 5 * L0 + 4 * CPB0 + CPB0 / 2) @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(negedge clk);
    check("mid_frame_reset", {txd0, ready0, busy0, done0}, 4'b1100);
    ok = 1;
    for (int i = 0; i < 3 * L0; i++) begin
      @(negedge clk);
      if (done0 !== 1'b0 || txd0 !== 1'b1 || ready0 !== 1'b1) ok = 0;
    end
    check("no_done_after_reset", ok, 1);
    rdata = {$urandom, $urandom, $urandom, $urandom};
    send(0, 1'b1, 8'hC3, rdata, 1'b0, 1'b1, t_acc);
    wait_idle(0);

    // Randomized frames.
    for (int i = 0; i < 4; i++) begin
      rdata = {$urandom, $urandom, $urandom, $urandom};
      rhdr  = 8'($urandom);
      rhe   = 1'($urandom);
      send(0, rhe, rhdr, rdata, 1'b0, 1'b1, t_acc);
      wait_idle(0);
    end

    // Gap instance: valid held high across two words, back-to-back frames.
    rdata = {$urandom, $urandom, $urandom, $urandom};
    send(1, 1'b1, 8'h77, rdata, 1'b1, 1'b1, t_acc);
    rdata = {$urandom, $urandom, $urandom, $urandom};
    send(1, 1'b0, 8'h00, rdata, 1'b0, 1'b1, t_dummy);
    check("b2b_second_accept", t_dummy, t_acc + 17 * L1 + 1);
    wait_idle(1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
